// File: rtl/sym_fir_core_if.sv
// -----------------------------------------------------------------------------
// sym_fir_core_if
// Sample and coefficient bus for sym_fir_core.
//   slave  : the filter core (takes samples/coefficients, drives results)
//   master : the producer/consumer side (ADC stream + adaptive update logic)
// Signals:
//   in_valid/in_data/mode  sample strobe, sample, 0=symmetric 1=antisymmetric
//   flush                  sync clear of delay line and in-flight results
//   coef_we/addr/data      shadow coefficient write
//   coef_commit            copy shadow bank to active bank
//   out_valid/data/sat     result strobe, result, saturation flag
// -----------------------------------------------------------------------------
interface sym_fir_core_if #(
  parameter int WL      = 14,
  parameter int COEF_WL = 9,
  parameter int OUT_WL  = 20,
  parameter int CA_W    = 3
);
  logic               in_valid;
  logic [WL-1:0]      in_data;
  logic               mode;
  logic               flush;
  logic               coef_we;
  logic [CA_W-1:0]    coef_addr;
  logic [COEF_WL-1:0] coef_data;
  logic               coef_commit;
  logic               out_valid;
  logic [OUT_WL-1:0]  out_data;
  logic               out_sat;

  modport master (
    output in_valid, in_data, mode, flush, coef_we, coef_addr, coef_data, coef_commit,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, mode, flush, coef_we, coef_addr, coef_data, coef_commit,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sym_fir_core.sv
// -----------------------------------------------------------------------------
// sym_fir_core
// Symmetric / antisymmetric fixed-point FIR, N = ORDER+1 taps, NC = N/2 unique
// coefficients in a double-buffered (shadow/active) bank.
// 3-stage pipeline advanced by the valid token:
//   S1 pre-add/sub of mirrored taps (coefficient set latched here)
//   S2 NC products (one sym_fir_lane per unique coefficient)
//   S3 sum, round-half-up, saturate
// Ports: clk, rst (async, active high), bus (sym_fir_core_if.slave).
// -----------------------------------------------------------------------------

// One unique-coefficient lane: pre-add (S1) then multiply (S2).
module sym_fir_lane #(
  parameter int WL      = 14,
  parameter int COEF_WL = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s1_en_i,
  input  logic                  s2_en_i,
  input  logic                  sub_i,
  input  logic [WL-1:0]         a_i,
  input  logic [WL-1:0]         b_i,
  input  logic [COEF_WL-1:0]    coef_i,
  output logic [WL+COEF_WL:0]   prod_o
);
  localparam int PW = WL + 1;
  localparam int MW = PW + COEF_WL;

  logic signed [PW-1:0]      pa_d, pa_q;
  logic signed [COEF_WL-1:0] coef_q;
  logic signed [MW-1:0]      prod_d, prod_q;

  always_comb begin
    pa_d   = sub_i ? (PW'($signed(a_i)) - PW'($signed(b_i)))
                   : (PW'($signed(a_i)) + PW'($signed(b_i)));
    prod_d = MW'(pa_q) * MW'(coef_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_q   <= '0;
      coef_q <= '0;
      prod_q <= '0;
    end else begin
      // coefficient travels with the sample so a commit never hits in-flight data
      if (s1_en_i) begin
        pa_q   <= pa_d;
        coef_q <= $signed(coef_i);
      end
      if (s2_en_i) prod_q <= prod_d;
    end
  end

  assign prod_o = prod_q;
endmodule

module sym_fir_core #(
  parameter int WL      = 14,
  parameter int FL      = 6,
  parameter int ORDER   = 9,
  parameter int COEF_WL = 9,
  parameter int COEF_FL = 7,
  parameter int OUT_WL  = 20,
  parameter int OUT_FL  = 12
) (
  input logic           clk,
  input logic           rst,
  sym_fir_core_if.slave bus
);
  localparam int N      = ORDER + 1;
  localparam int NC     = N / 2;
  localparam int MW     = WL + 1 + COEF_WL;
  localparam int SW     = MW + $clog2(NC);
  localparam int D      = FL + COEF_FL - OUT_FL;          // dropped fraction bits
  localparam int RW     = SW + 1;                         // room for the rounding add
  localparam int XW     = ((RW > OUT_WL) ? RW : OUT_WL) + 1;
  localparam int STAGES = 3;

  localparam logic signed [XW-1:0] HALF = (D > 0) ? (XW'(1) <<< ((D > 0) ? (D - 1) : 0)) : XW'(0);
  localparam logic signed [XW-1:0] MAXV = (XW'(1) <<< (OUT_WL - 1)) - XW'(1);
  localparam logic signed [XW-1:0] MINV = -MAXV - XW'(1);

  logic [NC-1:0][COEF_WL-1:0] shadow_q, shadow_d, active_q, active_d;
  logic [N-2:0][WL-1:0]       dl_q, dl_d;      // past samples, dl_q[0] newest
  logic [N-1:0][WL-1:0]       tap;             // window including the incoming sample
  logic [NC-1:0][MW-1:0]      prod;
  logic [STAGES:1]            vld_pipe_q, vld_pipe_d;
  logic [OUT_WL-1:0]          out_data_q, out_data_d;
  logic                       out_sat_q, out_sat_d;

  logic signed [SW-1:0]       acc;
  logic signed [XW-1:0]       ext, rnd;
  logic [OUT_WL-1:0]          res;
  logic                       res_sat;

  // Coefficient banks: commit reads the pre-write shadow since both are
  // sampled from the registered shadow.
  always_comb begin
    active_d = bus.coef_commit ? shadow_q : active_q;
    shadow_d = shadow_q;
    if (bus.coef_we && (int'(bus.coef_addr) < NC))
      shadow_d[bus.coef_addr] = bus.coef_data;
  end

  // Flush zeroes history but the accompanying sample still enters tap 0.
  always_comb begin
    tap[0] = bus.in_data;
    for (int i = 1; i < N; i++)
      tap[i] = bus.flush ? '0 : dl_q[i-1];
    dl_d = dl_q;
    if (bus.in_valid) begin
      for (int i = 0; i < N - 1; i++) dl_d[i] = tap[i];
    end else if (bus.flush) begin
      dl_d = '0;
    end
  end

  for (genvar k = 0; k < NC; k++) begin : g_lane
    sym_fir_lane #(.WL(WL), .COEF_WL(COEF_WL)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .s1_en_i (bus.in_valid),
      .s2_en_i (vld_pipe_q[1]),
      .sub_i   (bus.mode),
      .a_i     (tap[k]),
      .b_i     (tap[N-1-k]),
      .coef_i  (active_q[k]),
      .prod_o  (prod[k])
    );
  end

  // S3: sum, round-half-up via bias + arithmetic shift, clamp.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NC; k++) acc = acc + SW'($signed(prod[k]));
    ext     = XW'(acc);
    rnd     = (ext + HALF) >>> D;
    res     = rnd[OUT_WL-1:0];
    res_sat = 1'b0;
    if (rnd > MAXV) begin
      res     = MAXV[OUT_WL-1:0];
      res_sat = 1'b1;
    end else if (rnd < MINV) begin
      res     = MINV[OUT_WL-1:0];
      res_sat = 1'b1;
    end
  end

  // Flush kills tokens already in the pipe, never the one entering with it.
  always_comb begin
    vld_pipe_d[1] = bus.in_valid;
    for (int s = 2; s <= STAGES; s++)
      vld_pipe_d[s] = vld_pipe_q[s-1] & ~bus.flush;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (bus.flush) begin
      out_data_d = '0;
      out_sat_d  = 1'b0;
    end else if (vld_pipe_q[STAGES-1]) begin
      out_data_d = res;
      out_sat_d  = res_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= '0;
      active_q   <= '0;
      dl_q       <= '0;
      vld_pipe_q <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      dl_q       <= dl_d;
      vld_pipe_q <= vld_pipe_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule
